// File: rtl/register_file.sv
// RV32I integer register file: two combinational read ports, one synchronous write port.
// Register x0 always reads as zero and is never written with non-zero data.
module register_file #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] A1,
    input  logic [ADDR_WIDTH-1:0] A2,
    input  logic [ADDR_WIDTH-1:0] A3,
    input  logic                  WE3,
    input  logic [DATA_WIDTH-1:0] WD3,
    output logic [DATA_WIDTH-1:0] RD1,
    output logic [DATA_WIDTH-1:0] RD2
);

    localparam int unsigned NUM_REGS = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
    logic                  wr_en_c;

    // Writes to x0 are dropped so its storage only ever holds the reset value.
    assign wr_en_c = WE3 && (A3 != ADDR_WIDTH'(0));

    // Reset wins over a coincident write.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (wr_en_c) begin
            regs_q[A3] <= WD3;
        end
    end

    // No write-to-read forwarding; the hazard unit provides bypass.
    always_comb begin
        RD1 = '0;
        RD2 = '0;
        if (A1 != ADDR_WIDTH'(0)) RD1 = regs_q[A1];
        if (A2 != ADDR_WIDTH'(0)) RD2 = regs_q[A2];
    end

endmodule

// File: tb/tb_register_file.sv
// Self-checking bench for register_file: directed vectors with literal expectations
// plus a per-cycle comparison of both read ports against an architectural model.
module tb_register_file;

    localparam int unsigned DW = 32;
    localparam int unsigned AW = 5;
    localparam int unsigned NR = 32;

    logic          clk;
    logic          rst;
    logic [AW-1:0] A1, A2, A3;
    logic          WE3;
    logic [DW-1:0] WD3;
    logic [DW-1:0] RD1, RD2;

    int checks   = 0;
    int failures = 0;

    logic [DW-1:0] model [NR];
    bit            model_valid = 1'b0;

    register_file #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst(rst),
        .A1(A1), .A2(A2), .A3(A3),
        .WE3(WE3), .WD3(WD3),
        .RD1(RD1), .RD2(RD2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Architectural state: what the ISA says the registers hold after each edge.
    always @(posedge clk) begin
        if (rst) begin
            foreach (model[i]) model[i] = '0;
            model_valid = 1'b1;
        end else if (WE3 && A3 != 0) begin
            model[A3] = WD3;
        end
    end

    function automatic logic [DW-1:0] arch_read(input logic [AW-1:0] a);
        return (a == 0) ? '0 : model[a];
    endfunction

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Continuous comparison, mid-cycle, once the model is defined.
    always @(negedge clk) begin
        if (model_valid) begin
            check("model_rd1", RD1, arch_read(A1));
            check("model_rd2", RD2, arch_read(A2));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; WE3 = 1'b0; A1 = '0; A2 = '0; A3 = '0; WD3 = '0;

        // Reset then read
        step();
        rst = 1'b0; A1 = 5'd16; A2 = 5'd7;
        #1;
        check("reset_rd1", RD1, 32'h0);
        check("reset_rd2", RD2, 32'h0);

        // x0 protection
        WE3 = 1'b1; A3 = 5'd0; WD3 = 32'd15;
        step();
        A1 = 5'd0;
        #1;
        check("x0_write_ignored", RD1, 32'h0);

        // Writes and read-back
        A3 = 5'd1; step();
        A3 = 5'd2; step();
        WD3 = 32'd20; A3 = 5'd3; step();
        WE3 = 1'b0;
        A1 = 5'd0; A2 = 5'd1;
        #1;
        check("rb_x0", RD1, 32'h0);
        check("rb_x1", RD2, 32'd15);
        A1 = 5'd2; A2 = 5'd3;
        #1;
        check("rb_x2", RD1, 32'd15);
        check("rb_x3", RD2, 32'd20);

        // Write disable
        WE3 = 1'b0; A3 = 5'd3; WD3 = 32'hDEADBEEF;
        step();
        A1 = 5'd3;
        #1;
        check("we_off_x3", RD1, 32'd20);

        // Same-cycle read/write of one register: old value until the edge
        A1 = 5'd5; A2 = 5'd5; WE3 = 1'b1; A3 = 5'd5; WD3 = 32'hFFFFFFFF;
        #1;
        check("rw_before_rd1", RD1, 32'h0);
        check("rw_before_rd2", RD2, 32'h0);
        step();
        check("rw_after_rd1", RD1, 32'hFFFFFFFF);
        check("rw_after_rd2", RD2, 32'hFFFFFFFF);

        // Data is sampled only at the edge; later changes do not leak in
        A3 = 5'd7; WD3 = 32'h0000AAAA;
        step();
        WE3 = 1'b0; WD3 = 32'h0000BBBB; A3 = 5'd8;
        A1 = 5'd7; A2 = 5'd8;
        step();
        check("edge_sample_x7", RD1, 32'h0000AAAA);
        check("edge_sample_x8", RD2, 32'h0);

        // Zero overwrites a stored value
        WE3 = 1'b1; A3 = 5'd1; WD3 = 32'h0;
        step();
        WE3 = 1'b0; A1 = 5'd1;
        #1;
        check("zero_write_x1", RD1, 32'h0);

        // Fill every register with a distinct pattern, then sweep both ports
        WE3 = 1'b1;
        for (int i = 0; i < int'(NR); i++) begin
            A3 = AW'(i);
            WD3 = 32'hA5000000 ^ (32'(i) * 32'h00010203);
            step();
        end
        WE3 = 1'b0;
        for (int i = 0; i < int'(NR); i++) begin
            A1 = AW'(i);
            A2 = AW'(NR - 1 - i);
            step();
        end
        A1 = 5'd31; A2 = 5'd31;
        #1;
        check("fill_x31_rd1", RD1, 32'hA5000000 ^ (32'd31 * 32'h00010203));
        check("fill_x31_rd2", RD2, 32'hA51F3E5D);
        A1 = 5'd0;
        #1;
        check("fill_x0", RD1, 32'h0);

        // Reset beats a simultaneous write
        rst = 1'b1; WE3 = 1'b1; A3 = 5'd4; WD3 = 32'h1234;
        step();
        rst = 1'b0; WE3 = 1'b0;
        A1 = 5'd4; A2 = 5'd31;
        #1;
        check("rst_vs_wr_x4", RD1, 32'h0);
        check("rst_clears_x31", RD2, 32'h0);
        for (int i = 1; i <= 3; i++) begin
            A1 = AW'(i);
            #1;
            check("rst_clears_x1_3", RD1, 32'h0);
        end
        step();
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
